seg_display_arbiter: RTL and testbench

Owns the 4-digit multiplexed 7-segment display and time-shares it between two requesters: the IR receive path (32-bit code plus valid strobe) and a 16-bit status word.
- A received IR code takes display ownership for a programmable hold time; the display then falls back to status.
- Also generates the digit scan schedule, including anti-ghosting blanking, from the 50 MHz system clock.

---
 rtl/seg_display_arbiter_pkg.sv | 13 +
 rtl/seg_display_arbiter_if.sv | 13 +
 rtl/seg_display_arbiter_scan_prescaler.sv | 27 ++
 rtl/seg_display_arbiter.sv | 77 +++++++
 tb/tb_seg_display_arbiter.sv | 186 ++++++++++++++++++
 5 files changed

// File: rtl/seg_display_arbiter_pkg.sv
// seg_pkg: shared constants and state encoding for the display arbiter
package seg_pkg;
    typedef enum logic {IDLE = 1'b0, SHOW_CODE = 1'b1} state_t;
    localparam logic [3:0] DIG_OFF = 4'b1111;
    localparam logic [6:0] SEG_OFF = 7'h7F;
    localparam logic [15:0][6:0] HEX7 = {
        7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
        7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
    };
    function automatic logic [6:0] hex7(input logic [3:0] n);
        return HEX7[n];
    endfunction
endpackage

// File: rtl/seg_display_arbiter_if.sv
// seg_display_arbiter_if: requester inputs and display outputs of the arbiter
interface seg_display_arbiter_if;
    logic [31:0] code_in;
    logic        code_valid;
    logic        btn_sel;
    logic [15:0] status_in;
    logic [3:0]  dig;
    logic [6:0]  seg;
    logic        owner;
    logic [31:0] code_hold;
    modport master (output code_in, code_valid, btn_sel, status_in, input dig, seg, owner, code_hold);
    modport slave  (input code_in, code_valid, btn_sel, status_in, output dig, seg, owner, code_hold);
endinterface

// File: rtl/seg_display_arbiter_scan_prescaler.sv
// scan_prescaler: scan tick generation and post-tick blanking window
module scan_prescaler #(
    parameter int CLK_DIV      = 50000,
    parameter int BLANK_CYCLES = 500
) (
    input  logic clk,
    input  logic res,
    output logic scan_tick,
    output logic blank_active,
    output logic digit_load
);
    logic [15:0] cnt;
    logic [15:0] bcnt;
    assign scan_tick    = cnt == 16'(CLK_DIV - 1);
    assign blank_active = bcnt != 16'd0;
    assign digit_load   = bcnt == 16'd1;
    // free-running prescaler plus a blanking countdown restarted by every tick
    always_ff @(posedge clk) begin
        if (res) begin
            cnt  <= '0;
            bcnt <= '0;
        end else begin
            cnt  <= scan_tick ? '0 : cnt + 16'd1;
            bcnt <= scan_tick ? 16'(BLANK_CYCLES) : blank_active ? bcnt - 16'd1 : bcnt;
        end
    end
endmodule

// File: rtl/seg_display_arbiter.sv
// seg_display_arbiter: time-shares the 4-digit display between IR codes and status
module seg_display_arbiter
    import seg_pkg::*;
#(
    parameter int CLK_DIV      = 50000,
    parameter int BLANK_CYCLES = 500,
    parameter int HOLD_TICKS   = 2000
) (
    input logic clk,
    input logic res,
    seg_display_arbiter_if.slave bus
);
    logic        scan_tick;
    logic        blank_active;
    logic        digit_load;
    state_t      state;
    state_t      nstate;
    logic        valid_q;
    logic        rise;
    logic        expire;
    logic [15:0] hcnt;
    logic [1:0]  idx;
    logic [15:0] word;
    logic [3:0]  nib;

    scan_prescaler #(.CLK_DIV(CLK_DIV), .BLANK_CYCLES(BLANK_CYCLES)) u_pre (
        .clk(clk),
        .res(res),
        .scan_tick(scan_tick),
        .blank_active(blank_active),
        .digit_load(digit_load)
    );

    assign rise   = bus.code_valid & ~valid_q;
    assign expire = state == SHOW_CODE && scan_tick && hcnt == 16'd1;

    // ownership state register
    always_ff @(posedge clk) begin
        state <= res ? IDLE : nstate;
    end

    // a fresh capture always wins over an expiring hold
    always_comb begin
        nstate = rise ? SHOW_CODE : expire ? IDLE : state;
    end

    // owner flag and the word/nibble the next digit load will show
    always_comb begin
        bus.owner = state == SHOW_CODE;
        word      = state == SHOW_CODE ? (bus.btn_sel ? bus.code_hold[15:0] : bus.code_hold[31:16]) : bus.status_in;
        nib       = word[{idx, 2'b00} +: 4];
    end

    // capture, hold countdown and digit scan datapath
    always_ff @(posedge clk) begin
        if (res) begin
            valid_q       <= 1'b0;
            bus.code_hold <= '0;
            hcnt          <= '0;
            idx           <= '0;
            bus.dig       <= DIG_OFF;
            bus.seg       <= SEG_OFF;
        end else begin
            valid_q <= bus.code_valid;
            if (rise)
                bus.code_hold <= bus.code_in;
            hcnt <= rise ? 16'(HOLD_TICKS) : (state == SHOW_CODE && scan_tick) ? hcnt - 16'd1 : hcnt;
            if (digit_load) begin
                bus.dig <= ~(4'b0001 << idx);
                bus.seg <= ~hex7(nib);
                idx     <= idx + 2'd1;
            end else if (scan_tick || blank_active) begin
                bus.dig <= DIG_OFF;
            end
        end
    end
endmodule

// File: tb/tb_seg_display_arbiter.sv
// tb_seg_display_arbiter: randomized scoreboard bench against a tick-level reference model
module tb_seg_display_arbiter;
    localparam int CLK_DIV      = 4;
    localparam int BLANK_CYCLES = 1;
    localparam int HOLD_TICKS   = 8;
    localparam logic [6:0] HEX [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

    logic clk = 1'b0;
    logic res = 1'b1;
    seg_display_arbiter_if bus();

    seg_display_arbiter #(.CLK_DIV(CLK_DIV), .BLANK_CYCLES(BLANK_CYCLES), .HOLD_TICKS(HOLD_TICKS)) dut (
        .clk(clk),
        .res(res),
        .bus(bus)
    );

    always #5 clk = ~clk;

    int compared   = 0;
    int mismatched = 0;
    logic [10:0] expq[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // reference model: ownership expressed as a deadline in scan-tick numbers
    int          m_pc      = 0;
    int          m_tickno  = 0;
    int          m_expire  = 0;
    logic [1:0]  m_idx     = 0;
    logic        m_owner   = 0;
    logic        m_vq      = 0;
    logic        m_started = 0;
    logic        m_inreset = 1;
    logic [31:0] m_hold    = 0;
    logic        m_tick;
    logic        m_rise;
    logic [15:0] m_word;
    logic [3:0]  m_nib;

    always @(posedge clk) begin
        if (res) begin
            m_pc = 0; m_tickno = 0; m_expire = 0; m_idx = 0;
            m_owner = 0; m_vq = 0; m_started = 0; m_hold = 0; m_inreset = 1;
            expq.delete();
        end else begin
            m_inreset = 0;
            m_tick = m_pc == CLK_DIV - 1;
            if (m_started && m_pc == BLANK_CYCLES - 1) begin
                m_word = m_owner ? (bus.btn_sel ? m_hold[15:0] : m_hold[31:16]) : bus.status_in;
                m_nib  = m_word[{m_idx, 2'b00} +: 4];
                expq.push_back({~(4'b0001 << m_idx), ~HEX[m_nib]});
                m_idx = m_idx + 2'd1;
            end
            if (m_tick) begin
                m_started = 1;
                m_tickno++;
            end
            m_rise = bus.code_valid && !m_vq;
            m_vq   = bus.code_valid;
            if (m_rise) begin
                m_hold   = bus.code_in;
                m_owner  = 1;
                m_expire = m_tickno + HOLD_TICKS;
            end else if (m_owner && m_tickno == m_expire) begin
                m_owner = 0;
            end
            m_pc = (m_pc + 1) % CLK_DIV;
        end
    end

    // monitor: per-cycle ownership checks and a scoreboard pop on each digit load
    logic [3:0]  prev_dig = 4'hF;
    int          wait_cyc = 0;
    logic [10:0] e;

    always @(negedge clk) begin
        chk("owner", 32'(bus.owner), 32'(m_owner));
        chk("code_hold", bus.code_hold, m_hold);
        if (m_inreset) begin
            chk("reset_dig", 32'(bus.dig), 32'h0000000F);
            chk("reset_seg", 32'(bus.seg), 32'h0000007F);
        end else if (bus.dig != prev_dig && bus.dig != 4'hF) begin
            chk("blank_before_load", 32'(prev_dig), 32'h0000000F);
            if (expq.size() == 0) begin
                compared++;
                mismatched++;
                $display("FAIL unexpected_load: dig %b seg %h with nothing expected", bus.dig, bus.seg);
            end else begin
                e = expq.pop_front();
                chk("load_dig", 32'(bus.dig), 32'(e[10:7]));
                chk("load_seg", 32'(bus.seg), 32'(e[6:0]));
            end
        end
        wait_cyc = expq.size() != 0 ? wait_cyc + 1 : 0;
        if (wait_cyc > 2 * CLK_DIV) begin
            compared++;
            mismatched++;
            e = expq.pop_front();
            $display("FAIL load_timeout: expected dig %b seg %h never shown", e[10:7], e[6:0]);
            wait_cyc = 0;
        end
        prev_dig = bus.dig;
    end

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse(input logic [31:0] code, input int len);
        bus.code_in    = code;
        bus.code_valid = 1'b1;
        cycles(1);
        bus.code_in    = $urandom;
        cycles(len - 1);
        bus.code_valid = 1'b0;
    endtask

    initial begin
        bool_found: begin end
    end

    initial begin
        bit found;
        logic [31:0] c2;
        bus.code_in    = '0;
        bus.code_valid = 1'b0;
        bus.btn_sel    = 1'b0;
        bus.status_in  = 16'h1234;
        res = 1'b1;
        cycles(3);
        chk("rst_dig", 32'(bus.dig), 32'h0000000F);
        chk("rst_seg", 32'(bus.seg), 32'h0000007F);
        res = 1'b0;
        cycles(40);
        pulse(32'hA5C3_0F1E, 1);
        chk("owner_after_edge", 32'(bus.owner), 32'h1);
        chk("hold_after_edge", bus.code_hold, 32'hA5C3_0F1E);
        cycles(17);
        bus.btn_sel = 1'b1;
        cycles(50);
        pulse(32'h1357_9BDF, 1);
        found = 0;
        for (int i = 0; i < 200 && !found; i++) begin
            if (m_owner && m_expire - m_tickno == 1 && m_pc == CLK_DIV - 1) found = 1;
            else cycles(1);
        end
        if (!found) begin
            compared++;
            mismatched++;
            $display("FAIL coincide_wait: expiring tick not reached, got none, expected one");
        end
        c2 = $urandom;
        pulse(c2, 1);
        chk("coincide_owner", 32'(bus.owner), 32'h1);
        chk("coincide_hold", bus.code_hold, c2);
        cycles(60);
        c2 = $urandom;
        pulse(c2, 20);
        chk("level_hold", bus.code_hold, c2);
        cycles(10);
        res = 1'b1;
        cycles(1);
        chk("midres_owner", 32'(bus.owner), 32'h0);
        chk("midres_dig", 32'(bus.dig), 32'h0000000F);
        chk("midres_hold", bus.code_hold, 32'h0);
        res = 1'b0;
        for (int i = 0; i < 60; i++) begin
            bus.status_in = 16'($urandom);
            if ($urandom_range(0, 2) == 0) bus.btn_sel = ~bus.btn_sel;
            if ($urandom_range(0, 1) == 0) pulse($urandom, $urandom_range(1, 20));
            cycles($urandom_range(1, 30));
        end
        cycles(50);
        chk("queue_empty", 32'(expq.size()), 32'h0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
